// File: rtl/seg7_bin_display.sv
// seg7_bin_display
//   Sequential binary-to-decimal converter driving DIGITS registered
//   7-segment patterns. A start in IDLE captures value. WIDTH shift-and-add-3
//   steps follow, then one LOAD cycle that writes segments/overflow and
//   pulses done.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, value    conversion request / unsigned operand (WIDTH bits)
//   busy            high from the accepted start until the LOAD edge
//   done            one-cycle pulse on the first cycle of new segments
//   overflow        last converted value was >= 10**DIGITS
//   segments        {a..g} per digit, a = MSB, digit 0 (units) in [6:0]
module seg7_bin_display #(
  parameter int WIDTH      = 6,
  parameter int DIGITS     = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);
  // Patterns are built active-low; XOR flips them for active-high boards.
  localparam logic [6:0] POL = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic [7*DIGITS-1:0] BLANK_ALL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d;

  logic [BW-1:0]        adj;
  logic [7*DIGITS-1:0]  seg_new;
  logic                 lz;
  logic [3:0]           nib;
  logic [6:0]           pat;

  // Active-low abcdefg; codes 10..15 only reachable under overflow (dashes).
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0001100;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Display image of the finished BCD; scanned from the top digit so that
  // zeros stay blank until the first nonzero digit. Units always shown.
  always_comb begin
    seg_new = '0;
    lz      = (BLANK_LZ != 0);
    nib     = '0;
    pat     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (ovf_pend_q)                   pat = 7'b1111110;
      else if (lz && i != 0 && nib == 4'd0) pat = 7'b1111111;
      else begin
        pat = dec7(nib);
        lz  = 1'b0;
      end
      seg_new[7*i +: 7] = pat ^ POL;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    seg_d      = seg_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        bin_d      = value;
        bcd_d      = '0;
        cnt_d      = CW'(WIDTH);
        ovf_pend_d = (32'(value) >= LIMIT);
        state_d    = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        seg_d   = seg_new;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= BLANK_ALL;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign segments = seg_q;

endmodule
